// File: rtl/mem_bridge.sv
// -----------------------------------------------------------------------------
// mem_bridge
//   Converts core load/store requests (byte/half/word, LSB-aligned data) into
//   word-addressed bus accesses with byte-lane enables. Loads come back shifted
//   to bit 0 and zero- or sign-extended.
//
//   Optional feature macro: MEM_BRIDGE_SPLIT_EN
//     defined   : misaligned accesses are split into two word accesses
//                 (lower word / upper lanes, then addr+4 / lower lanes).
//     undefined : misaligned accesses issue no bus cycle and report err.
//
//   Ports
//     clk, rstn            clock, asynchronous active-low reset
//     rmem, wmem           core load / store request (both high = store)
//     mem_addr             byte address
//     mem_wdata            store data, LSB-aligned
//     mem_type             00 byte, 01 half, 10 word
//     mem_sign             1 = sign-extend load result
//     mem_rdata            aligned, extended load data (held until next DONE)
//     busy                 core must hold its request while high
//     err                  one-cycle error pulse (misalign or timeout)
//     bus_req/bus_we       bus access valid / write strobe
//     bus_addr/bus_be      word address / byte-lane enables
//     bus_wdata            lane-positioned write data
//     bus_rdata/bus_ack    read word / access complete
//     dbg_state            current FSM state (IDLE=0, ACC0=1, ACC1=2, DONE=3)
//
//   Handshake: bus_req acts as "valid" and bus_ack as "complete". Once bus_req
//   rises, bus_we/bus_addr/bus_be/bus_wdata stay constant until the cycle in
//   which bus_ack is sampled high; bus_ack is ignored whenever bus_req is low.
//   On the core side, a request seen in IDLE raises busy in the same cycle and
//   busy stays high until the DONE cycle, where mem_rdata/err are valid.
// -----------------------------------------------------------------------------
module mem_bridge #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] RST_RDATA = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rmem,
  input  logic        wmem,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_type,
  input  logic        mem_sign,
  output logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_e;

  // Counter only needs to reach TIMEOUT-1: the abort fires in the wait cycle
  // that would otherwise be the TIMEOUT-th one without an ack.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [1:0]     type_q, type_d;
  logic           sign_q, sign_d;
  logic [1:0]     off_q, off_d;
  logic           span_q, span_d;
  logic [3:0]     hi_be_q, hi_be_d;
  logic [31:0]    hi_wdata_q, hi_wdata_d;
  logic [31:0]    lo_word_q, lo_word_d;
  logic           err_q, err_d;
  logic [31:0]    bus_addr_q, bus_addr_d;
  logic [3:0]     bus_be_q, bus_be_d;
  logic [31:0]    bus_wdata_q, bus_wdata_d;
  logic [31:0]    rdata_q, rdata_d;

  // ---------------------------------------------------------------------------
  // Request decode. Lanes are computed across an 8-byte window so an access
  // that runs past the end of its word yields the second word's lanes/data
  // in the upper half.
  // ---------------------------------------------------------------------------
  logic [1:0]  req_off;
  logic [3:0]  base_be;
  logic [7:0]  be8;
  logic [63:0] wdata64;
  logic        misal;

  always_comb begin
    req_off = mem_addr[1:0];
    if (mem_type[1]) begin
      base_be = 4'hF;
    end else if (mem_type[0]) begin
      base_be = 4'h3;
    end else begin
      base_be = 4'h1;
    end
    be8     = {4'b0000, base_be} << req_off;
    wdata64 = {32'h0, mem_wdata} << {req_off, 3'b000};
    misal   = (mem_type[1] && (req_off != 2'b00)) ||
              (!mem_type[1] && mem_type[0] && req_off[0]);
  end

  // Selects the addressed bytes out of the (upper, lower) word pair and
  // extends them according to size and signedness.
  function automatic logic [31:0] load_fmt(input logic [63:0] pair,
                                           input logic [1:0]  off,
                                           input logic [1:0]  typ,
                                           input logic        sgn);
    logic [31:0] sel;
    sel = 32'(pair >> {off, 3'b000});
    if (typ[1]) begin
      return sel;
    end else if (typ[0]) begin
      return sgn ? {{16{sel[15]}}, sel[15:0]} : {16'h0, sel[15:0]};
    end else begin
      return sgn ? {{24{sel[7]}}, sel[7:0]} : {24'h0, sel[7:0]};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    type_d      = type_q;
    sign_d      = sign_q;
    off_d       = off_q;
    span_d      = span_q;
    hi_be_d     = hi_be_q;
    hi_wdata_d  = hi_wdata_q;
    lo_word_d   = lo_word_q;
    err_d       = err_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        if (rmem || wmem) begin
          we_d        = wmem;  // simultaneous rmem/wmem is a store
          type_d      = mem_type;
          sign_d      = mem_sign;
          off_d       = req_off;
          span_d      = |be8[7:4];
          hi_be_d     = be8[7:4];
          hi_wdata_d  = wdata64[63:32];
          bus_addr_d  = {mem_addr[31:2], 2'b00};
          bus_be_d    = be8[3:0];
          bus_wdata_d = wdata64[31:0];
          cnt_d       = '0;
          err_d       = 1'b0;
`ifdef MEM_BRIDGE_SPLIT_EN
          state_d     = ACC0;
`else
          if (misal) begin
            // No bus cycle at all; report the error in the DONE cycle.
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = RST_RDATA;
          end else begin
            state_d = ACC0;
          end
`endif
        end
      end

      ACC0: begin
        if (bus_ack) begin
          lo_word_d = bus_rdata;
          if (span_q) begin
            state_d     = ACC1;
            cnt_d       = '0;
            bus_addr_d  = bus_addr_q + 32'd4;
            bus_be_d    = hi_be_q;
            bus_wdata_d = hi_wdata_q;
          end else begin
            state_d = DONE;
            if (!we_q) begin
              rdata_d = load_fmt({32'h0, bus_rdata}, off_q, type_q, sign_q);
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = RST_RDATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ACC1: begin
        if (bus_ack) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = load_fmt({bus_rdata, lo_word_q}, off_q, type_q, sign_q);
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abort drops the remaining word of a split store.
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = RST_RDATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      type_q      <= 2'b00;
      sign_q      <= 1'b0;
      off_q       <= 2'b00;
      span_q      <= 1'b0;
      hi_be_q     <= 4'h0;
      hi_wdata_q  <= 32'h0;
      lo_word_q   <= 32'h0;
      err_q       <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      rdata_q     <= RST_RDATA;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      type_q      <= type_d;
      sign_q      <= sign_d;
      off_q       <= off_d;
      span_q      <= span_d;
      hi_be_q     <= hi_be_d;
      hi_wdata_q  <= hi_wdata_d;
      lo_word_q   <= lo_word_d;
      err_q       <= err_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. busy is gated by rstn so an asserted reset clears it even while
  // the core keeps its request high.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_req   = (state_q == ACC0) || (state_q == ACC1);
    bus_we    = bus_req && we_q;
    busy      = rstn && (bus_req || ((state_q == IDLE) && (rmem || wmem)));
    err       = (state_q == DONE) && err_q;
    mem_rdata = rdata_q;
    bus_addr  = bus_addr_q;
    bus_be    = bus_be_q;
    bus_wdata = bus_wdata_q;
    dbg_state = state_q;
  end

endmodule
